memoria_dados_param: RTL and testbench
======================================

Name: memoria_dados_param

Overview:
- Parametrised, handshaked data memory for the CPU datapath; successor to the fixed 2048x32 word-addressed data RAM.
- Adds byte addressing, byte/half/word accesses with byte-lane writes, and sign/zero extension on loads.
- Adds misalignment detection and configurable wait states, via a req/ack handshake.
- Sits between the MEM stage and on-chip block RAM; storage remains inferable as synchronous RAM.

Parameters:
- DEPTH, 2048, number of 32-bit words; power of two.
- ADDR_W, 13, byte-address width; must equal log2(DEPTH)+2.
- WAIT_STATES, 0, extra cycles inserted before each access commits (0..15).

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  reset; synchronous, active-low.
- req  input  1  access request; sampled only when busy=0.
- we  input  1  1=store, 0=load; sampled with req.
- size  input  2  00=byte, 01=half, 10=word, 11=reserved (flagged as err).
- unsigned_ld  input  1  1=zero-extend loads, 0=sign-extend; sampled with req.
- addr  input  ADDR_W  byte address; sampled with req.
- wdata  input  32  store data; the low byte/half is used for narrow stores; sampled with req.
- rdata  output  32  load result; valid while ack=1 and held until the next ack.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; 1=misaligned or reserved size, access suppressed.
- busy  output  1  high from the cycle after an accepted req until ack is deasserted.

Behaviour:
- Reset (reset_n=0 at posedge):
  - FSM goes to IDLE; rdata=0, ack=0, err=0, busy=0; wait counter=0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts it; a store not yet committed is never written.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - On req=1, latch we/size/unsigned_ld/addr/wdata and set busy=1.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11: go to RESP with err=1.
  - Otherwise go to WAIT if WAIT_STATES>0, else to ACCESS.
- WAIT: count WAIT_STATES cycles, then go to ACCESS.
- ACCESS (exactly one cycle):
  - Word index = addr[ADDR_W-1:2].
  - Store: write only the selected byte lanes.
    - Byte: lane addr[1:0] gets wdata[7:0].
    - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
    - Word: all four lanes.
  - Load: synchronous read of the whole word into an internal register.
  - Next state is RESP.
- RESP (one cycle):
  - ack=1.
  - Load: rdata = selected byte/half shifted to bit 0, then sign- or zero-extended to 32 bits; word loads pass through unchanged.
  - Store: rdata holds its previous value.
  - err=1 only for rejected accesses; a rejected load leaves rdata unchanged.
  - Next state is IDLE; busy=0 from the next cycle.
- Latency: req accepted at cycle T gives ack at cycle T+2+WAIT_STATES; an error ack comes at T+1.
- req while busy=1 is ignored; the requester must hold req until busy rises or ack arrives.
- Back-to-back accesses: a new req may be accepted in the cycle after ack.
- A load issued after a store to the same word returns the new data; accesses never overlap.
- Byte lane 0 is bits [7:0] (little-endian).

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - Each byte lane stores one extra even-parity bit, written with that lane.
  - On load, every lane in the selected word is checked; any mismatch sets err=1 with ack.
  - rdata is still returned on a parity error.
  - Adds port par_inject (input, 1 bit): when 1 during a store, the stored parity bits are inverted.
- Not defined:
  - No parity storage and no par_inject port.
  - err reflects only misalignment and reserved size.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with req=1 -> ack=0, busy=0, rdata=0, err=0, and no write occurs.
- Word store 0xDEADBEEF at addr 0x10, then word load from 0x10 (WAIT_STATES=0) -> ack 2 cycles after each req, rdata=0xDEADBEEF, err=0.
- Byte store 0x80 at addr 0x13, then signed byte load from 0x13 -> rdata=0xFFFFFF80; unsigned byte load from 0x13 -> rdata=0x00000080; word load from 0x10 -> 0x80ADBEEF.
- Half load from addr 0x11, and word store to 0x12 -> ack at T+1 with err=1; a word load from 0x10 still returns 0x80ADBEEF.
- WAIT_STATES=3:
  - Word load -> ack at T+5 with busy high throughout.
  - A second req pulsed mid-operation is ignored.
  - Asserting reset_n=0 during WAIT of a store aborts it; a later load shows the old data.
- DMEM_PARITY_EN: store 0x12345678 with par_inject=1 to addr 0x20, then load from 0x20 -> rdata=0x12345678, err=1; a store with par_inject=0 followed by a load -> err=0.

Source files
------------

// File: rtl/memoria_dados_param_if.sv
// Request/response bundle between the MEM stage and memoria_dados_param.
// Master drives the request fields, slave returns rdata/ack/err/busy.
// Optional DMEM_PARITY_EN adds the par_inject request field.
interface memoria_dados_param_if #(
  parameter int ADDR_W = 13
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;
`ifdef DMEM_PARITY_EN
  logic              par_inject;
`endif

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
`ifdef DMEM_PARITY_EN
    output par_inject,
`endif
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
`ifdef DMEM_PARITY_EN
    input  par_inject,
`endif
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/memoria_dados_param.sv
// Byte-addressed data RAM with byte/half/word access, load extension and misalignment check.
// Latency: ack at T+2+WAIT_STATES after req accepted at T; rejected access acks at T+1.
// Backpressure: one access in flight; req ignored while busy, requester holds req until busy/ack.
// Optional parity per byte lane enabled by macro DMEM_PARITY_EN (adds par_inject).
module memoria_dados_param #(
  parameter int DEPTH       = 2048,
  parameter int ADDR_W      = 13,
  parameter int WAIT_STATES = 0
) (
  input logic                    clock,
  input logic                    reset_n,
  memoria_dados_param_if.slave   bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Elaboration-time sanity on the geometry parameters.
  if (ADDR_W != $clog2(DEPTH) + 2) begin : g_bad_addr_w
    $error("memoria_dados_param: ADDR_W must equal log2(DEPTH)+2");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("memoria_dados_param: WAIT_STATES must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [31:0]       rdata_q, rdata_d;

  // Request fields captured at acceptance.
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rej_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word_q;

  logic              accept;
  logic              rej_in;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lane_en;
  logic [31:0]       wlane;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic              is_load_resp;
  logic              par_err;

`ifdef DMEM_PARITY_EN
  logic [3:0]        par_mem [DEPTH];
  logic [3:0]        rd_par_q;
  logic              inj_q;
  logic [3:0]        wpar;
`endif

  assign accept = (state_q == S_IDLE) && bus.req;

  // Reserved size or a narrow access that straddles its natural alignment.
  assign rej_in = (bus.size == 2'b11) ||
                  ((bus.size == 2'b01) && bus.addr[0]) ||
                  ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

  // State register and wait counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: reject straight to RESP, otherwise optional WAIT then one ACCESS cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (rej_in)               state_d = S_RESP;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WS_LAST) state_d = S_ACCESS;
        else                   wcnt_d  = wcnt_q + 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the request fields when the access is accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rej_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.we;
      size_q  <= bus.size;
      uns_q   <= bus.unsigned_ld;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      rej_q   <= rej_in;
    end
  end

`ifdef DMEM_PARITY_EN
  // Parity inject flag travels with the request.
  always_ff @(posedge clock) begin
    if (!reset_n)    inj_q <= 1'b0;
    else if (accept) inj_q <= bus.par_inject;
  end
`endif

  assign idx = addr_q[ADDR_W-1:2];

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    lane_en = 4'b0000;
    wlane   = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en = 4'b0001 << addr_q[1:0];
        wlane   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata_q[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

`ifdef DMEM_PARITY_EN
  // Even parity per lane, optionally inverted to exercise the checker.
  always_comb begin
    wpar = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      wpar[l] = (^wlane[8*l +: 8]) ^ inj_q;
    end
  end
`endif

  // RAM port: store touches only enabled lanes, load reads the whole word; gated by reset so
  // an aborted access never commits.
  always_ff @(posedge clock) begin
    if (reset_n && (state_q == S_ACCESS)) begin
      if (we_q) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_en[l]) begin
            mem[idx][8*l +: 8] <= wlane[8*l +: 8];
`ifdef DMEM_PARITY_EN
            par_mem[idx][l] <= wpar[l];
`endif
          end
        end
      end else begin
        rd_word_q <= mem[idx];
`ifdef DMEM_PARITY_EN
        rd_par_q  <= par_mem[idx];
`endif
      end
    end
  end

  // Shift the selected byte/half down to bit 0 and extend.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = rd_word_q[7:0];
      2'b01:   ld_byte = rd_word_q[15:8];
      2'b10:   ld_byte = rd_word_q[23:16];
      default: ld_byte = rd_word_q[31:24];
    endcase
    ld_half = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = rd_word_q;
    endcase
  end

  assign is_load_resp = (state_q == S_RESP) && !we_q && !rej_q;

`ifdef DMEM_PARITY_EN
  // Any lane of the loaded word whose stored parity disagrees flags an error.
  always_comb begin
    par_err = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if ((^rd_word_q[8*l +: 8]) != rd_par_q[l]) par_err = is_load_resp;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Outputs: rdata shows the fresh load during RESP and holds it afterwards.
  always_comb begin
    rdata_d = rdata_q;
    if (is_load_resp) rdata_d = ld_ext;
    bus.rdata = rdata_d;
    bus.ack   = (state_q == S_RESP);
    bus.err   = (state_q == S_RESP) && (rej_q || par_err);
    bus.busy  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_memoria_dados_param.sv
module tb_memoria_dados_param;

  logic clock = 1'b0;
  logic rst0_n, rst3_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  memoria_dados_param_if #(.ADDR_W(13)) if0 ();
  memoria_dados_param_if #(.ADDR_W(13)) if3 ();

  memoria_dados_param #(.DEPTH(2048), .ADDR_W(13), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset_n(rst0_n), .bus(if0));
  memoria_dados_param #(.DEPTH(2048), .ADDR_W(13), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset_n(rst3_n), .bus(if3));

  // One access on the zero-wait instance; lat counts cycles after the accepting edge.
  task automatic acc0(input logic w, input logic [1:0] sz, input logic un, input logic [12:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic er, output logic bz);
    @(negedge clock);
    if0.req = 1'b1; if0.we = w; if0.size = sz; if0.unsigned_ld = un; if0.addr = a; if0.wdata = wd;
    @(posedge clock); #1 if0.req = 1'b0;
    lat = -1; rd = '0; er = 1'b0; bz = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clock);
      if (!if0.busy) bz = 1'b0;
      if (if0.ack) begin lat = k; rd = if0.rdata; er = if0.err; end
    end
  endtask

  // Same on the three-wait instance, optionally pulsing a stray store request mid-operation.
  task automatic acc3(input logic w, input logic [1:0] sz, input logic [12:0] a,
                      input logic [31:0] wd, input logic mid, output int lat,
                      output logic [31:0] rd, output logic er, output logic bz);
    @(negedge clock);
    if3.req = 1'b1; if3.we = w; if3.size = sz; if3.unsigned_ld = 1'b0; if3.addr = a; if3.wdata = wd;
    @(posedge clock); #1 if3.req = 1'b0;
    lat = -1; rd = '0; er = 1'b0; bz = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clock);
      if (!if3.busy) bz = 1'b0;
      if (if3.ack) begin lat = k; rd = if3.rdata; er = if3.err; end
      if (mid && k == 2) begin if3.req = 1'b1; if3.we = 1'b1; if3.wdata = 32'hBAD0BAD0; end
      if (mid && k == 3) if3.req = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic er, bz;
    rst0_n = 1'b0; rst3_n = 1'b0;
    if0.req = 1'b1; if0.we = 1'b1; if0.size = 2'b10; if0.addr = 13'h30; if0.wdata = 32'hCAFEBABE;
    if3.req = 1'b1; if3.we = 1'b1; if3.size = 2'b10; if3.addr = 13'h40; if3.wdata = 32'hCAFEBABE;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (if0.ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", if0.ack); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", if0.busy); end
    total++; if (if0.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", if0.rdata); end
    total++; if (if0.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", if0.err); end
    total++; if (if3.busy !== 1'b0) begin bad++; $display("FAIL rst3_busy got=%b exp=0", if3.busy); end
    if0.req = 1'b0; if3.req = 1'b0; rst0_n = 1'b1; rst3_n = 1'b1;
    // Known content, then a store held under reset must not land.
    acc0(1'b1, 2'b10, 1'b0, 13'h30, 32'h01020304, lat, rd, er, bz);
    @(negedge clock);
    rst0_n = 1'b0;
    if0.req = 1'b1; if0.we = 1'b1; if0.size = 2'b10; if0.addr = 13'h30; if0.wdata = 32'hCAFEBABE;
    repeat (2) @(posedge clock);
    @(negedge clock);
    if0.req = 1'b0; rst0_n = 1'b1;
    acc0(1'b0, 2'b10, 1'b0, 13'h30, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL rst_nowrite got=%h exp=01020304", rd); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, bz;
    acc0(1'b1, 2'b10, 1'b0, 13'h10, 32'hDEADBEEF, lat, rd, er, bz);
    total++; if (lat !== 2) begin bad++; $display("FAIL wst_lat got=%0d exp=2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wst_err got=%b exp=0", er); end
    acc0(1'b0, 2'b10, 1'b0, 13'h10, 32'h0, lat, rd, er, bz);
    total++; if (lat !== 2) begin bad++; $display("FAIL wld_lat got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wld_data got=%h exp=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wld_err got=%b exp=0", er); end
    @(negedge clock);
    total++; if (if0.busy !== 1'b0 || if0.ack !== 1'b0) begin
      bad++; $display("FAIL post_ack busy=%b ack=%b exp=0/0", if0.busy, if0.ack); end
  endtask

  task automatic test_narrow();
    int lat; logic [31:0] rd; logic er, bz;
    acc0(1'b1, 2'b00, 1'b0, 13'h13, 32'h12345680, lat, rd, er, bz);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL st_hold got=%h exp=deadbeef", rd); end
    acc0(1'b0, 2'b00, 1'b0, 13'h13, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_s got=%h exp=ffffff80", rd); end
    acc0(1'b0, 2'b00, 1'b1, 13'h13, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lb_u got=%h exp=00000080", rd); end
    acc0(1'b0, 2'b10, 1'b0, 13'h10, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_mix got=%h exp=80adbeef", rd); end
    acc0(1'b0, 2'b01, 1'b0, 13'h12, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'hFFFF80AD) begin bad++; $display("FAIL lh_s got=%h exp=ffff80ad", rd); end
    acc0(1'b0, 2'b01, 1'b1, 13'h10, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL lh_u got=%h exp=0000beef", rd); end
    acc0(1'b0, 2'b00, 1'b0, 13'h11, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_s1 got=%h exp=ffffffbe", rd); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic er, bz;
    acc0(1'b0, 2'b01, 1'b0, 13'h11, 32'h0, lat, rd, er, bz);
    total++; if (lat !== 1) begin bad++; $display("FAIL mh_lat got=%0d exp=1", lat); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mh_err got=%b exp=1", er); end
    total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL mh_hold got=%h exp=ffffffbe", rd); end
    acc0(1'b1, 2'b10, 1'b0, 13'h12, 32'h55555555, lat, rd, er, bz);
    total++; if (lat !== 1 || er !== 1'b1) begin
      bad++; $display("FAIL mw_st lat=%0d err=%b exp=1/1", lat, er); end
    acc0(1'b1, 2'b11, 1'b0, 13'h10, 32'h66666666, lat, rd, er, bz);
    total++; if (lat !== 1 || er !== 1'b1) begin
      bad++; $display("FAIL rsv_sz lat=%0d err=%b exp=1/1", lat, er); end
    acc0(1'b0, 2'b10, 1'b0, 13'h10, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL mis_nowrite got=%h err=%b exp=80adbeef/0", rd, er); end
  endtask

  task automatic test_wait_states();
    int lat, extra; logic [31:0] rd; logic er, bz;
    acc3(1'b1, 2'b10, 13'h40, 32'hA5A5F00F, 1'b0, lat, rd, er, bz);
    total++; if (lat !== 5) begin bad++; $display("FAIL ws_st_lat got=%0d exp=5", lat); end
    acc3(1'b0, 2'b10, 13'h40, 32'h0, 1'b1, lat, rd, er, bz);
    total++; if (lat !== 5) begin bad++; $display("FAIL ws_ld_lat got=%0d exp=5", lat); end
    total++; if (bz !== 1'b1) begin bad++; $display("FAIL ws_busy got=%b exp=1", bz); end
    total++; if (rd !== 32'hA5A5F00F) begin bad++; $display("FAIL ws_ld_data got=%h exp=a5a5f00f", rd); end
    extra = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clock); if (if3.ack) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL ws_stray_ack got=%0d exp=0", extra); end
    acc3(1'b0, 2'b10, 13'h40, 32'h0, 1'b0, lat, rd, er, bz);
    total++; if (rd !== 32'hA5A5F00F) begin bad++; $display("FAIL ws_stray_wr got=%h exp=a5a5f00f", rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er, bz;
    @(negedge clock);
    if3.req = 1'b1; if3.we = 1'b1; if3.size = 2'b10; if3.addr = 13'h40; if3.wdata = 32'h99999999;
    @(posedge clock); #1 if3.req = 1'b0;
    @(negedge clock);
    rst3_n = 1'b0;
    @(negedge clock);
    rst3_n = 1'b1;
    total++; if (if3.busy !== 1'b0 || if3.ack !== 1'b0 || if3.rdata !== 32'h0) begin
      bad++; $display("FAIL abort_state busy=%b ack=%b rdata=%h exp=0/0/0", if3.busy, if3.ack, if3.rdata); end
    acc3(1'b0, 2'b10, 13'h40, 32'h0, 1'b0, lat, rd, er, bz);
    total++; if (rd !== 32'hA5A5F00F) begin bad++; $display("FAIL abort_data got=%h exp=a5a5f00f", rd); end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    int lat; logic [31:0] rd; logic er, bz;
    if0.par_inject = 1'b1;
    acc0(1'b1, 2'b10, 1'b0, 13'h20, 32'h12345678, lat, rd, er, bz);
    if0.par_inject = 1'b0;
    acc0(1'b0, 2'b10, 1'b0, 13'h20, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h12345678 || er !== 1'b1) begin
      bad++; $display("FAIL par_inj got=%h err=%b exp=12345678/1", rd, er); end
    acc0(1'b1, 2'b10, 1'b0, 13'h20, 32'h0F0F0F0E, lat, rd, er, bz);
    acc0(1'b0, 2'b10, 1'b0, 13'h20, 32'h0, lat, rd, er, bz);
    total++; if (rd !== 32'h0F0F0F0E || er !== 1'b0) begin
      bad++; $display("FAIL par_ok got=%h err=%b exp=0f0f0f0e/0", rd, er); end
  endtask
`endif

  initial begin
    if0.req = 1'b0; if0.we = 1'b0; if0.size = 2'b10; if0.unsigned_ld = 1'b0;
    if0.addr = '0; if0.wdata = '0;
    if3.req = 1'b0; if3.we = 1'b0; if3.size = 2'b10; if3.unsigned_ld = 1'b0;
    if3.addr = '0; if3.wdata = '0;
`ifdef DMEM_PARITY_EN
    if0.par_inject = 1'b0; if3.par_inject = 1'b0;
`endif
    rst0_n = 1'b0; rst3_n = 1'b0;
    test_reset();
    test_word();
    test_narrow();
    test_misalign();
    test_wait_states();
    test_reset_abort();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
